irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Machine-level interrupt controller that produces the `interrupt`/`cause` request consumed by the CSR trap logic.
- Collects software, timer and NUM_SRC external sources, applying enable masks, edge/level pending capture, fixed priority and a request/ack/return handshake.
- Also owns a 32-bit mtime/mtimecmp timer and a small register window written by CSR-style accesses.

Parameters:
- NUM_SRC, 8, number of external interrupt sources (1..16).
- SRC_BASE, 16, cause code of src[0]; src[i] cause = SRC_BASE+i; SRC_BASE+NUM_SRC-1 must be <= 31.
- TICK_DIV, 1, clk cycles per mtime increment (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- src  in  NUM_SRC  external interrupt lines, synchronous to clk
- global_ie  in  1  mstatus.MIE; no new request is issued while low
- wr_en  in  1  register write strobe
- rd_en  in  1  register read strobe
- addr  in  3  register index
- wdata  in  32  write data
- rdata  out  32  read data (combinational; 0 when rd_en low)
- irq_ack  in  1  trap taken (driven from the CSR file's epc_taken)
- irq_ret  in  1  mret executed (is_mret)
- interrupt  out  1  request to the CSR file
- cause  out  5  cause code of the request
- in_service  out  1  a trap is being handled

Behaviour:
- Registers, by addr:
  - 0 ENABLE: [NUM_SRC-1:0] external, bit 16 software, bit 17 timer; RW.
  - 1 PENDING: same bit layout; RO except write-1-to-clear on edge-mode external bits.
  - 2 EDGE_SEL: bit i=1 means src[i] is rising-edge triggered; RW.
  - 3 MTIMECMP: RW.
  - 4 MTIME: RW.
  - 5 MSIP: bit 0 = software pending; RW.
  - 6, 7: read 0, writes ignored.
- Reset values:
  - All registers 0, except MTIMECMP = 32'hFFFF_FFFF.
  - Edge history 0; state IDLE.
  - interrupt=0, cause=0, in_service=0.
- mtime:
  - Increments by 1 every TICK_DIV cycles and wraps 32'hFFFF_FFFF -> 0.
  - A write to MTIME loads wdata and restarts the divider; the write wins over an increment in the same cycle.
- Pending:
  - Timer pending = (mtime >= mtimecmp), unsigned, combinational.
  - Software pending = MSIP[0].
  - Level-mode src[i]: pending = src[i].
  - Edge-mode src[i]: pending bit sets when src[i]=1 and the previous-cycle src[i]=0. It clears on W1C or when claimed by irq_ack. A set in the same cycle as a clear wins.
- Eligible = PENDING & ENABLE.
- Fixed priority: software (cause 3) > timer (cause 7) > src[0] > ... > src[NUM_SRC-1].
- FSM:
  - IDLE: if global_ie and any eligible, latch the winner's cause, assert interrupt, go to REQ. Transition takes 1 cycle: request visible the cycle after eligibility.
  - REQ: interrupt=1; cause is held stable, with no re-arbitration and no retraction even if the source deasserts. On irq_ack, clear that source's edge pending bit if edge-mode, drop interrupt, set in_service, go to SERVICE.
  - SERVICE: no new requests (no nesting). On irq_ret, clear in_service and go to IDLE. The next request can assert 1 cycle later at the earliest.
  - irq_ret while in IDLE or REQ: ignored.
  - irq_ack while in IDLE or SERVICE: ignored.
- global_ie falling while in REQ: request stays asserted (already committed).
- rst in any state: immediate return to IDLE with all reset values; pending edges are lost.
- Register write to ENABLE during REQ does not alter the latched cause.

Test Plan:
- Reset: after rst, interrupt=0, cause=0, in_service=0, read addr3 = FFFFFFFF, read addr4 = 0.
- Level source, single event: ENABLE=0x1, global_ie=1, src[0]=1.
  - Next cycle interrupt=1, cause=16.
  - irq_ack -> interrupt=0, in_service=1.
  - irq_ret -> in_service=0; src[0] still high -> re-requests cause=16.
- Priority: ENABLE=0x3_00FF, MSIP=1, mtimecmp=0, src=0xFF together -> cause=3.
  - Clear MSIP, ack, ret -> cause=7.
  - Set mtimecmp=FFFFFFFF, ack, ret -> cause=16.
- Edge source: EDGE_SEL[2]=1, ENABLE[2]=1, 1-cycle pulse on src[2] while in SERVICE.
  - PENDING reads 0x4 and no request is issued.
  - After irq_ret -> cause=18; after ack, PENDING bit 2 = 0.
- Timer wrap: TICK_DIV=1, write MTIME=FFFFFFFE, MTIMECMP=FFFFFFFF, ENABLE bit 17.
  - Interrupt asserts 2 cycles after the write (mtime=FFFFFFFF), cause=7.
  - mtime wraps to 0 -> PENDING bit 17 = 0; interrupt stays 1 until irq_ack.
- Mid-operation reset: assert rst while in REQ -> next cycle interrupt=0, PENDING=0, state IDLE; a later irq_ack has no effect.

Source files
------------

// File: rtl/irq_controller.sv
// Machine-level interrupt controller: enable masks, edge/level pending capture,
// fixed-priority arbitration, request/ack/return handshake and an mtime timer.
module irq_controller #(
    parameter int unsigned NUM_SRC  = 8,
    parameter int unsigned SRC_BASE = 16,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               global_ie,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic               irq_ack,
    input  logic               irq_ret,
    output logic               interrupt,
    output logic [4:0]         cause,
    output logic               in_service
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e             state_q, state_d;
    logic [4:0]         cause_q, cause_d;
    logic [NUM_SRC-1:0] en_ext_q, edge_sel_q, edge_pend_q, edge_pend_d, src_prev_q;
    logic               en_sw_q, en_tim_q, msip_q;
    logic [31:0]        mtime_q, mtimecmp_q, div_q;

    logic               tim_pend;
    logic [NUM_SRC-1:0] pend_ext, elig_ext, ack_clr, edge_set, w1c;
    logic               win_valid;
    logic [4:0]         win_cause;
    logic [31:0]        pending_word, enable_word, edge_sel_word;

    // Pending sources: timer compare, edge-captured or live level lines
    always_comb begin
        tim_pend      = (mtime_q >= mtimecmp_q);
        pend_ext      = (edge_sel_q & edge_pend_q) | (~edge_sel_q & src);
        elig_ext      = pend_ext & en_ext_q;
        pending_word  = '0;
        enable_word   = '0;
        edge_sel_word = '0;
        pending_word[NUM_SRC-1:0]  = pend_ext;
        pending_word[16]           = msip_q;
        pending_word[17]           = tim_pend;
        enable_word[NUM_SRC-1:0]   = en_ext_q;
        enable_word[16]            = en_sw_q;
        enable_word[17]            = en_tim_q;
        edge_sel_word[NUM_SRC-1:0] = edge_sel_q;
    end

    // Fixed priority: software > timer > src[0] > ... > src[NUM_SRC-1]
    always_comb begin
        win_valid = 1'b0;
        win_cause = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig_ext[i]) begin
                win_valid = 1'b1;
                win_cause = 5'(SRC_BASE + i);
            end
        end
        if (en_tim_q && tim_pend) begin
            win_valid = 1'b1;
            win_cause = 5'd7;
        end
        if (en_sw_q && msip_q) begin
            win_valid = 1'b1;
            win_cause = 5'd3;
        end
    end

    // Handshake FSM next state; ack also names the edge bit to consume
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ack_clr = '0;
        unique case (state_q)
            StIdle: begin
                if (global_ie && win_valid) begin
                    cause_d = win_cause;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (irq_ack) begin
                    state_d = StService;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (cause_q == 5'(SRC_BASE + i)) ack_clr[i] = 1'b1;
                    end
                end
            end
            StService: begin
                if (irq_ret) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Edge capture: a new edge in the same cycle as a clear wins
    always_comb begin
        edge_set    = src & ~src_prev_q & edge_sel_q;
        w1c         = (wr_en && addr == 3'd1) ? (wdata[NUM_SRC-1:0] & edge_sel_q) : '0;
        edge_pend_d = (edge_pend_q & ~(w1c | (ack_clr & edge_sel_q))) | edge_set;
    end

    // FSM, edge history and pending state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cause_q     <= '0;
            edge_pend_q <= '0;
            src_prev_q  <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            edge_pend_q <= edge_pend_d;
            src_prev_q  <= src;
        end
    end

    // Register window writes and the mtime divider; an MTIME write beats a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            en_ext_q   <= '0;
            en_sw_q    <= 1'b0;
            en_tim_q   <= 1'b0;
            edge_sel_q <= '0;
            msip_q     <= 1'b0;
            mtimecmp_q <= 32'hFFFF_FFFF;
            mtime_q    <= '0;
            div_q      <= '0;
        end else begin
            if (div_q == TICK_DIV - 1) begin
                div_q   <= '0;
                mtime_q <= mtime_q + 32'd1;
            end else begin
                div_q <= div_q + 32'd1;
            end
            if (wr_en) begin
                case (addr)
                    3'd0: begin
                        en_ext_q <= wdata[NUM_SRC-1:0];
                        en_sw_q  <= wdata[16];
                        en_tim_q <= wdata[17];
                    end
                    3'd2: edge_sel_q <= wdata[NUM_SRC-1:0];
                    3'd3: mtimecmp_q <= wdata;
                    3'd4: begin
                        mtime_q <= wdata;
                        div_q   <= '0;
                    end
                    3'd5: msip_q <= wdata[0];
                    default: ;
                endcase
            end
        end
    end

    // Combinational read port
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                3'd0:    rdata = enable_word;
                3'd1:    rdata = pending_word;
                3'd2:    rdata = edge_sel_word;
                3'd3:    rdata = mtimecmp_q;
                3'd4:    rdata = mtime_q;
                3'd5:    rdata = {31'd0, msip_q};
                default: rdata = '0;
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        interrupt  = (state_q == StReq);
        in_service = (state_q == StService);
        cause      = cause_q;
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  src;
    logic        global_ie, wr_en, rd_en, irq_ack, irq_ret;
    logic [2:0]  addr;
    logic [31:0] wdata, rdata;
    logic        interrupt, in_service;
    logic [4:0]  cause;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;

    irq_controller #(.NUM_SRC(8), .SRC_BASE(16), .TICK_DIV(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .global_ie  (global_ie),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq_ack    (irq_ack),
        .irq_ret    (irq_ret),
        .interrupt  (interrupt),
        .cause      (cause),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        tick();
        wr_en = 1'b0; wdata = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        rd_en = 1'b1; addr = a;
        #1;
        d = rdata;
        rd_en = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic ret();
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    endtask

    task automatic do_reset();
        src = '0; global_ie = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0;
        wdata = '0; irq_ack = 1'b0; irq_ret = 1'b0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_int", 32'(interrupt), 32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_insvc", 32'(in_service), 32'd0);
        rd(3'd3, rv); check("rst_mtimecmp", rv, 32'hFFFF_FFFF);
        rd(3'd4, rv); check("rst_mtime", rv, 32'd0);
        rd(3'd6, rv); check("rd_addr6", rv, 32'd0);

        // Level source
        do_reset();
        wr(3'd0, 32'h1);
        global_ie = 1'b1; src = 8'h01;
        #1; check("lvl_int_pre", 32'(interrupt), 32'd0);
        tick();
        check("lvl_int", 32'(interrupt), 32'd1);
        check("lvl_cause", 32'(cause), 32'd16);
        ack();
        check("lvl_ack_int", 32'(interrupt), 32'd0);
        check("lvl_ack_svc", 32'(in_service), 32'd1);
        tick();
        check("lvl_no_nest", 32'(interrupt), 32'd0);
        ret();
        check("lvl_ret_svc", 32'(in_service), 32'd0);
        check("lvl_ret_int", 32'(interrupt), 32'd0);
        tick();
        check("lvl_rereq", 32'(interrupt), 32'd1);
        check("lvl_rereq_cause", 32'(cause), 32'd16);

        // Priority
        do_reset();
        wr(3'd0, 32'h0003_00FF);
        wr(3'd5, 32'h1);
        wr(3'd3, 32'h0);
        src = 8'hFF; global_ie = 1'b1;
        tick();
        check("pri_sw", 32'(cause), 32'd3);
        wr(3'd5, 32'h0);
        check("pri_hold", 32'(cause), 32'd3);
        ack(); ret(); tick();
        check("pri_tim", 32'(cause), 32'd7);
        check("pri_tim_int", 32'(interrupt), 32'd1);
        wr(3'd3, 32'hFFFF_FFFF);
        ack(); ret(); tick();
        check("pri_src0", 32'(cause), 32'd16);

        // Edge source pulse while in service
        do_reset();
        wr(3'd2, 32'h4);
        wr(3'd0, 32'h0001_0004);
        wr(3'd5, 32'h1);
        global_ie = 1'b1;
        tick();
        check("edg_sw", 32'(cause), 32'd3);
        wr(3'd5, 32'h0);
        ack();
        src = 8'h04; tick(); src = 8'h00;
        tick();
        rd(3'd1, rv); check("edg_pend", rv, 32'h4);
        check("edg_no_req", 32'(interrupt), 32'd0);
        ret(); tick();
        check("edg_cause", 32'(cause), 32'd18);
        ack();
        rd(3'd1, rv); check("edg_claimed", rv, 32'h0);
        ret();
        global_ie = 1'b0;
        src = 8'h04; tick(); src = 8'h00;
        rd(3'd1, rv); check("edg_pend2", rv, 32'h4);
        wr(3'd1, 32'h4);
        rd(3'd1, rv); check("edg_w1c", rv, 32'h0);

        // Timer wrap
        do_reset();
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd0, 32'h0002_0000);
        global_ie = 1'b1;
        wr(3'd4, 32'hFFFF_FFFE);
        check("tim_int_w0", 32'(interrupt), 32'd0);
        tick();
        rd(3'd4, rv); check("tim_mtime_max", rv, 32'hFFFF_FFFF);
        check("tim_int_w1", 32'(interrupt), 32'd0);
        tick();
        check("tim_int_w2", 32'(interrupt), 32'd1);
        check("tim_cause", 32'(cause), 32'd7);
        rd(3'd1, rv); check("tim_pend_wrap", rv, 32'h0);
        tick(); tick();
        check("tim_int_held", 32'(interrupt), 32'd1);
        ack();
        check("tim_int_ack", 32'(interrupt), 32'd0);

        // Mid-operation reset
        do_reset();
        wr(3'd0, 32'h0001_0000);
        wr(3'd5, 32'h1);
        global_ie = 1'b1;
        tick();
        check("mrst_req", 32'(interrupt), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_int", 32'(interrupt), 32'd0);
        check("mrst_cause", 32'(cause), 32'd0);
        rd(3'd1, rv); check("mrst_pend", rv, 32'h0);
        ack();
        check("mrst_ack_int", 32'(interrupt), 32'd0);
        check("mrst_ack_svc", 32'(in_service), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
